// File: rtl/fetch_unit_if.sv
// Instruction bus between fetch_unit (master) and the memory side (slave).
interface fetch_unit_if;
  // Handshake: a request is accepted in the cycle ireq_valid && ireq_addr_ok;
  // once raised, ireq_valid/ireq_addr stay stable until accepted. Responses
  // (iresp_data_ok) come back one word per cycle in acceptance order, at the
  // earliest the cycle after acceptance, with no backpressure from the master.
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid, ireq_addr,
    input  ireq_addr_ok, iresp_data_ok, iresp_data
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output ireq_addr_ok, iresp_data_ok, iresp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS IF stage: PC register, split-handshake instruction fetch, response FIFO.
// Optional macro FETCH_ADDR_CHECK_EN adds misaligned-PC detection (fetch_adel).
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter int          BUF_DEPTH       = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master ibus,
  input  logic         StallF,
  input  logic         PCSrcD,
  input  logic [31:0]  PCBranchD,
  output logic         out_valid,
  output logic [31:0]  out_instr,
  output logic [31:0]  PCF,
  output logic [31:0]  PCPlus4F,
  input  logic         out_ready
`ifdef FETCH_ADDR_CHECK_EN
  ,
  output logic         fetch_adel
`endif
);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    WAIT_ADDR     = 2'd1,
    REDIRECT_PEND = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_next, held_addr;
  logic [OW-1:0] outstanding, outstanding_n, drop;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [QW-1:0] pcq_wr, pcq_rd;
  logic [31:0] instr_mem [BUF_DEPTH];
  logic [31:0] pc_mem    [BUF_DEPTH];
  logic [31:0] pcq       [MAX_OUTSTANDING];

  logic        credit_ok, pc_ok, issue_new;
  logic        acc, dok, keep, push, pop;
  logic [31:0] push_instr, push_pc;

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
    if (p == QW'(MAX_OUTSTANDING - 1)) return '0;
    return p + QW'(1);
  endfunction

  // Live credit: words buffered plus requests whose data will be kept.
  always_comb begin
    credit_ok = (int'(outstanding) < MAX_OUTSTANDING) &&
                ((int'(count) + int'(outstanding) - int'(drop)) < BUF_DEPTH);
  end

  assign acc           = ibus.ireq_valid && ibus.ireq_addr_ok;
  assign dok           = ibus.iresp_data_ok;
  assign keep          = dok && (drop == '0);
  assign pop           = out_valid && out_ready;
  assign outstanding_n = outstanding + OW'(acc) - OW'(dok);

`ifdef FETCH_ADDR_CHECK_EN
  logic halted, adel_go;
  logic adel_mem [BUF_DEPTH];

  assign pc_ok   = (pc_next[1:0] == 2'b00);
  // A misaligned PC becomes a marker entry once all live responses are in.
  assign adel_go = (state == IDLE) && !reset && !pc_ok && !halted && !StallF &&
                   (outstanding == drop) && (int'(count) < BUF_DEPTH);
  assign push       = keep || adel_go;
  assign push_instr = adel_go ? 32'h0 : ibus.iresp_data;
  assign push_pc    = adel_go ? pc_next : pcq[pcq_rd];

  always_ff @(posedge clk) begin
    if (reset)       halted <= 1'b0;
    else if (PCSrcD) halted <= 1'b0;
    else if (adel_go) halted <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !PCSrcD) adel_mem[wr_ptr] <= adel_go;
  end

  assign fetch_adel = out_valid && adel_mem[rd_ptr];
`else
  assign pc_ok      = 1'b1;
  assign push       = keep;
  assign push_instr = ibus.iresp_data;
  assign push_pc    = pcq[pcq_rd];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (issue_new && !ibus.ireq_addr_ok)
          state_n = PCSrcD ? REDIRECT_PEND : WAIT_ADDR;
      WAIT_ADDR:
        if (ibus.ireq_addr_ok) state_n = IDLE;
        else if (PCSrcD)       state_n = REDIRECT_PEND;
      REDIRECT_PEND:
        if (ibus.ireq_addr_ok) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    issue_new       = (state == IDLE) && !reset && !StallF && credit_ok && pc_ok;
    ibus.ireq_valid = !reset && ((state != IDLE) || issue_new);
    ibus.ireq_addr  = (state == IDLE) ? pc_next : held_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_next     <= RESET_PC;
      held_addr   <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      if (state == IDLE) held_addr <= pc_next;
      // A request held across a redirect carries the old PC; do not advance.
      if (PCSrcD)                              pc_next <= PCBranchD;
      else if (acc && state != REDIRECT_PEND)  pc_next <= pc_next + 32'd4;

      outstanding <= outstanding_n;
      if (PCSrcD) drop <= outstanding_n;
      else        drop <= drop - OW'(dok && (drop != '0)) +
                          OW'(acc && (state == REDIRECT_PEND));

      if (acc) pcq_wr <= q_inc(pcq_wr);
      if (dok) pcq_rd <= q_inc(pcq_rd);

      if (PCSrcD) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !PCSrcD) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
    if (acc) pcq[pcq_wr] <= ibus.ireq_addr;
  end

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'h0;
  assign PCF       = out_valid ? pc_mem[rd_ptr] : 32'h0;
  assign PCPlus4F  = PCF + 32'd4;

  // The credit scheme should make a push into a full, non-draining FIFO impossible.
  assert property (@(posedge clk) disable iff (reset)
    !(push && (count == CW'(BUF_DEPTH)) && !pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bus responder, sequential-PC delivery model.
// Build with FETCH_ADDR_CHECK_EN defined to exercise the misaligned-PC path.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC        = 32'hbfc00000;
  localparam int          BUF_DEPTH       = 2;
  localparam int          MAX_OUTSTANDING = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, PCSrcD, out_ready, out_valid;
  logic [31:0] PCBranchD, out_instr, PCF, PCPlus4F;
`ifdef FETCH_ADDR_CHECK_EN
  logic        fetch_adel;
  logic        last_adel;
`endif

  fetch_unit_if ibus ();

  fetch_unit #(
    .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk(clk), .reset(reset), .ibus(ibus),
    .StallF(StallF), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .out_valid(out_valid), .out_instr(out_instr), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .out_ready(out_ready)
`ifdef FETCH_ADDR_CHECK_EN
    , .fetch_adel(fetch_adel)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, deliveries = 0;

  // Stimulus knobs applied on each tick.
  bit          set_stall, set_redir, set_ready;
  logic [31:0] set_target;
  int          aok_pct, dok_pct;

  // Reference model: decode sees consecutive PCs starting at the last redirect.
  logic [31:0] exp_pc, exp_req, last_pc, hold_addr_prev;
  bit          hold_prev, hold_stale;
  logic [31:0] req_q[$];
  int          req_c[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h8badf00d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; StallF = 1'b0; PCSrcD = 1'b0; PCBranchD = '0; out_ready = 1'b0;
    ibus.ireq_addr_ok = 1'b0; ibus.iresp_data_ok = 1'b0; ibus.iresp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ireq_valid", ibus.ireq_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_pcf", PCF, 0);
    check("rst_pcplus4", PCPlus4F, 4);
    check("rst_instr", out_instr, 0);
`ifdef FETCH_ADDR_CHECK_EN
    check("rst_adel", fetch_adel, 0);
`endif
    reset = 1'b0;
    req_q.delete(); req_c.delete();
    exp_pc = RESET_PC; exp_req = RESET_PC;
    hold_prev = 1'b0; hold_stale = 1'b0;
  endtask

  // One clock cycle: drive inputs, sample just after, update model, advance.
  task automatic tick();
    logic [31:0] e_instr;
    StallF = set_stall; PCSrcD = set_redir; PCBranchD = set_target; out_ready = set_ready;
    ibus.ireq_addr_ok = ($urandom_range(99) < aok_pct);
    if (req_q.size() > 0 && req_c[0] < cyc && $urandom_range(99) < dok_pct) begin
      ibus.iresp_data_ok = 1'b1;
      ibus.iresp_data    = instr_of(req_q[0]);
    end else begin
      ibus.iresp_data_ok = 1'b0;
      ibus.iresp_data    = $urandom;
    end
    #1;
    if (hold_prev) begin
      check("hold_valid", ibus.ireq_valid, 1);
      check("hold_addr", ibus.ireq_addr, hold_addr_prev);
    end
    if (out_valid && out_ready) begin
      e_instr = (exp_pc[1:0] != 2'b00) ? 32'h0 : instr_of(exp_pc);
      check("deliver_pcf", PCF, exp_pc);
      check("deliver_instr", out_instr, e_instr);
      check("deliver_pcplus4", PCPlus4F, exp_pc + 32'd4);
`ifdef FETCH_ADDR_CHECK_EN
      check("deliver_adel", fetch_adel, exp_pc[1:0] != 2'b00);
      last_adel = fetch_adel;
`endif
      last_pc = PCF;
      exp_pc  = exp_pc + 32'd4;
      deliveries++;
    end
    if (ibus.ireq_valid && ibus.ireq_addr_ok) begin
`ifdef FETCH_ADDR_CHECK_EN
      check("req_aligned", ibus.ireq_addr[1:0], 0);
`endif
      if (PCSrcD || hold_stale) hold_stale = 1'b0;
      else begin
        check("req_addr", ibus.ireq_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
      req_q.push_back(ibus.ireq_addr);
      req_c.push_back(cyc);
    end else if (PCSrcD && ibus.ireq_valid) begin
      hold_stale = 1'b1;
    end
    if (ibus.iresp_data_ok) begin
      void'(req_q.pop_front());
      void'(req_c.pop_front());
    end
    check("outstanding_bound", req_q.size() <= MAX_OUTSTANDING, 1);
    if (PCSrcD) begin
      exp_pc  = PCBranchD;
      exp_req = PCBranchD;
    end
    hold_prev      = ibus.ireq_valid && !ibus.ireq_addr_ok;
    hold_addr_prev = ibus.ireq_addr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_deliver(input int n, input int budget, input string tag);
    int target;
    int k;
    target = deliveries + n;
    k = 0;
    while (deliveries < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, deliveries >= target, 1);
  endtask

  initial begin
    int k;
    logic [31:0] hold_base;
    set_stall = 0; set_redir = 0; set_ready = 1; set_target = '0;
    aok_pct = 100; dok_pct = 100;
    do_reset();

    // Straight-line fetch from RESET_PC.
    wait_deliver(4, 50, "seq_progress");
    check("seq_last_pc", last_pc, RESET_PC + 32'd12);

    // Decode stalled: buffer fills, requests stop, then drains in order.
    set_ready = 0;
    repeat (6) tick();
    #1;
    check("full_no_req", ibus.ireq_valid, 0);
    check("full_out_valid", out_valid, 1);
    set_ready = 1;
    wait_deliver(6, 60, "release_progress");

    // Redirect with two requests in flight: both late words dropped.
    dok_pct = 0;
    k = 0;
    while (req_q.size() < 2 && k < 20) begin tick(); k++; end
    check("two_outstanding", req_q.size(), 2);
    set_redir = 1; set_target = 32'hbfc00100; tick(); set_redir = 0;
    dok_pct = 100;
    wait_deliver(1, 40, "redir_progress");
    check("redir_first_pc", last_pc, 32'hbfc00100);

    // Held request across StallF pulses and a redirect.
    aok_pct = 0;
    k = 0;
    while (!hold_prev && k < 20) begin tick(); k++; end
    check("hold_started", hold_prev, 1);
    hold_base = hold_addr_prev;
    set_stall = 1; tick();
    set_stall = 0; set_redir = 1; set_target = 32'hbfc00200; tick();
    set_redir = 0; set_stall = 1; tick();
    set_stall = 0;
    check("hold_base_addr", hold_addr_prev, hold_base);
    aok_pct = 100;
    wait_deliver(1, 40, "hold_progress");
    check("hold_redir_pc", last_pc, 32'hbfc00200);

    // PC wrap at 2^32.
    set_redir = 1; set_target = 32'hfffffffc; tick(); set_redir = 0;
    wait_deliver(2, 40, "wrap_progress");
    check("wrap_pc", last_pc, 32'h00000000);

`ifdef FETCH_ADDR_CHECK_EN
    set_redir = 1; set_target = 32'hbfc00102; tick(); set_redir = 0;
    wait_deliver(1, 40, "adel_progress");
    check("adel_pc", last_pc, 32'hbfc00102);
    check("adel_flag", last_adel, 1);
    k = deliveries;
    repeat (10) tick();
    check("adel_halt", deliveries, k);
    set_redir = 1; set_target = RESET_PC; tick(); set_redir = 0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      set_stall  = ($urandom_range(99) < 20);
      set_ready  = ($urandom_range(99) < 70);
      set_redir  = ($urandom_range(99) < 3);
      set_target = ($urandom_range(9) == 0) ? 32'hfffffff8
                                            : RESET_PC + ($urandom_range(0, 1023) << 2);
      aok_pct = 60; dok_pct = 60;
      tick();
    end
    set_stall = 0; set_redir = 0; set_ready = 1; aok_pct = 100; dok_pct = 100;
    wait_deliver(4, 100, "drain_progress");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC register and drives the instruction bus request (addr/addr_ok, data_ok split handshake).
- Buffers returned instruction words in a small FIFO and presents them in order, with their PCs, to decode.
- Takes branch/jump redirects (PCSrcD/PCBranchD) from decode and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'hbfc00000, PC fetched first after reset.
- BUF_DEPTH, 2, instruction FIFO entries; power of two, range 2..8.
- MAX_OUTSTANDING, 2, maximum requests accepted (addr_ok) but not yet returned (data_ok); range 1..BUF_DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ireq_valid  output  1  instruction bus request valid.
- ireq_addr  output  32  instruction bus request address.
- ireq_addr_ok  input  1  bus accepted the request this cycle.
- iresp_data_ok  input  1  instruction word returned this cycle, in request order.
- iresp_data  input  32  returned instruction word.
- StallF  input  1  hazard unit: hold PC; no new request may be issued.
- PCSrcD  input  1  decode: redirect fetch this cycle.
- PCBranchD  input  32  redirect target.
- out_valid  output  1  FIFO head valid, offered to decode.
- out_instr  output  32  head instruction word.
- PCF  output  32  PC of head instruction.
- PCPlus4F  output  32  PCF + 4, modulo 2^32.
- out_ready  input  1  decode consumes head this cycle (driven as !StallD).

Behaviour:
- Reset (one cycle, sync): pc_next=RESET_PC; FIFO empty; outstanding=0; drop=0; ireq_valid=0; out_valid=0; PCF=0; PCPlus4F=4; out_instr=0. A reset asserted while a request is pending discards all state; responses arriving after reset are not tracked by the block (bus is reset together with it).
- Issue rule: ireq_valid=1 when !StallF && outstanding<MAX_OUTSTANDING && (fifo_count+outstanding-drop)<BUF_DEPTH.
- Hold rule: once ireq_valid=1 and ireq_addr_ok=0, ireq_valid and ireq_addr stay stable until addr_ok, regardless of StallF or redirect.
- On addr_ok: outstanding++; pc_next += 4 (wraps at 2^32).
- On data_ok: outstanding--. If drop>0, then drop-- and the word is discarded; otherwise the word is pushed with its PC. The PC is tracked by a per-request PC queue of depth MAX_OUTSTANDING.
- Pop: out_valid && out_ready removes the head. Push and pop in the same cycle are allowed when the FIFO is full. A word arriving with the FIFO empty appears on out_* the next cycle (1-cycle response-to-decode latency).
- Redirect (PCSrcD=1):
  - Next cycle: pc_next=PCBranchD; FIFO flushed; drop=outstanding (after this cycle's addr_ok/data_ok updates).
  - A request held mid-handshake is counted into drop when its addr_ok arrives.
  - PCSrcD and out_ready in the same cycle: the pop and the flush both happen.
  - Delay slot: decode must have consumed the slot before asserting PCSrcD; the block does not preserve it.
- Simultaneous addr_ok and data_ok: net outstanding change is 0.
- Credit rule guarantees no data_ok ever arrives with a full FIFO; an assertion must flag it if one does.
- FSM: IDLE (no pending addr), WAIT_ADDR (ireq_valid held), REDIRECT_PEND (held request to be dropped). WAIT_ADDR→IDLE on addr_ok. WAIT_ADDR→REDIRECT_PEND on PCSrcD. REDIRECT_PEND→IDLE on addr_ok.

Optional Feature:
- FETCH_ADDR_CHECK_EN
- Defined:
  - Adds output fetch_adel (1 bit).
  - If pc_next[1:0]!=0, no bus request is issued. Instead a pseudo-entry (out_instr=32'h0, PCF=bad PC) is pushed with fetch_adel=1.
  - Fetch then halts until the next redirect or reset.
- Not defined: port absent; address bits [1:0] are sent to the bus unchanged.

Test Plan:
- Reset, then addr_ok always 1 and data_ok one cycle later → addresses bfc00000, bfc00004, bfc00008…; first out_valid with PCF=bfc00000, PCPlus4F=bfc00004.
- out_ready=0 for 6 cycles → at most BUF_DEPTH=2 words buffered, ireq_valid deasserts. On release, words are delivered in order with no loss or duplication.
- Two requests outstanding, PCSrcD=1 with PCBranchD=bfc00100 → both late responses dropped; next out_valid has PCF=bfc00100.
- ireq_addr_ok held 0 for 3 cycles while StallF pulses and PCSrcD fires → ireq_addr stable at the original value; its response dropped; next request is the redirect target.
- Redirect to fffffffc → fetch fffffffc then 00000000 (wrap).
- FETCH_ADDR_CHECK_EN defined, redirect to bfc00102 → no bus request; fetch_adel=1 with PCF=bfc00102.
